// File: rtl/fluxo_dados_param.sv
// Datapath for the sequence memory game: counters, move register, LED and timing windows.
// Latency: registered state updates in 1 cycle, comparators combinational; no backpressure.
module fluxo_dados_param #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int T_ON  = 50,
  parameter int T_OFF = 50,
  parameter int T_TO  = 5000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     zeraE,
  input  logic                     contaE,
  input  logic                     zeraS,
  input  logic                     contaS,
  input  logic                     zeraR,
  input  logic                     registraR,
  input  logic                     escreveM,
  input  logic                     estado_espera,
  input  logic                     estado_ledsOn,
  input  logic                     estado_ledsOff,
  input  logic [W-1:0]             chaves,
  output logic                     jogadaIgualMemoria,
  output logic                     enderecoIgualSequencia,
  output logic                     tem_jogada,
  output logic                     fimS,
  output logic                     fimLedsOn,
  output logic                     fimLedsOff,
  output logic                     timeout,
  output logic                     jogada_valida,
  output logic [W-1:0]             leds,
  output logic [$clog2(DEPTH)-1:0] db_endereco,
  output logic [$clog2(DEPTH)-1:0] db_sequencia,
  output logic [W-1:0]             db_memoria,
  output logic [W-1:0]             db_jogada
);

  localparam int AW   = $clog2(DEPTH);
  localparam int ONW  = $clog2(T_ON);
  localparam int OFFW = $clog2(T_OFF);
  localparam int TOW  = $clog2(T_TO);

  localparam logic [AW-1:0]   E_LAST  = AW'(DEPTH - 1);
  localparam logic [ONW-1:0]  ON_MAX  = ONW'(T_ON - 1);
  localparam logic [OFFW-1:0] OFF_MAX = OFFW'(T_OFF - 1);
  localparam logic [TOW-1:0]  TO_MAX  = TOW'(T_TO - 1);

  // Power-up image: word i holds a one-hot symbol cycling through the W positions.
  function automatic logic [DEPTH*W-1:0] mem_init();
    logic [DEPTH*W-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v[i*W +: W] = W'(1) << (i % W);
    end
    return v;
  endfunction

  localparam logic [DEPTH*W-1:0] MEM_INIT = mem_init();

  logic [DEPTH*W-1:0] mem_q = MEM_INIT;

  logic [AW-1:0]   e_q, e_d;
  logic [AW-1:0]   s_q, s_d;
  logic [ONW-1:0]  on_q, on_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [TOW-1:0]  to_q, to_d;
  logic [W-1:0]    move_q, move_d;
  logic [W-1:0]    leds_q, leds_d;
  logic            tout_q, tout_d;
  logic            hist_q, hist_d;
  logic            tem_q, tem_d;

  logic [W-1:0]    mem_rd;
  logic            keys_any;

  assign mem_rd   = mem_q[int'(e_q)*W +: W];
  assign keys_any = |chaves;

  always_comb begin
    e_d    = e_q;
    s_d    = s_q;
    on_d   = on_q;
    off_d  = off_q;
    to_d   = to_q;
    move_d = move_q;
    leds_d = leds_q;
    tout_d = tout_q;
    hist_d = keys_any;
    tem_d  = keys_any & ~hist_q;

    if (zeraE)       e_d = '0;
    else if (contaE) e_d = e_q + AW'(1);

    if (zeraS)       s_d = '0;
    else if (contaS) s_d = s_q + AW'(1);

    if (zeraR)          move_d = '0;
    else if (registraR) move_d = chaves;

    // Each window timer is held in clear while the opposite phase is active.
    if (estado_ledsOff)                      on_d = '0;
    else if (estado_ledsOn && on_q != ON_MAX) on_d = on_q + ONW'(1);

    if (estado_ledsOn)                          off_d = '0;
    else if (estado_ledsOff && off_q != OFF_MAX) off_d = off_q + OFFW'(1);

    if (zeraE || keys_any)                     to_d = '0;
    else if (estado_espera && to_q != TO_MAX)  to_d = to_q + TOW'(1);

    if (zeraR)                tout_d = 1'b0;
    else if (to_q == TO_MAX)  tout_d = 1'b1;

    if (zeraR || estado_ledsOff || estado_espera) leds_d = '0;
    else if (estado_ledsOn)                       leds_d = mem_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_q    <= '0;
      s_q    <= '0;
      on_q   <= '0;
      off_q  <= '0;
      to_q   <= '0;
      move_q <= '0;
      leds_q <= '0;
      tout_q <= 1'b0;
      hist_q <= 1'b0;
      tem_q  <= 1'b0;
    end else begin
      e_q    <= e_d;
      s_q    <= s_d;
      on_q   <= on_d;
      off_q  <= off_d;
      to_q   <= to_d;
      move_q <= move_d;
      leds_q <= leds_d;
      tout_q <= tout_d;
      hist_q <= hist_d;
      tem_q  <= tem_d;
    end
  end

  // Memory keeps its contents across reset; writes are only blocked while reset is held.
  always_ff @(posedge clock) begin
    if (escreveM && !reset) begin
      mem_q[int'(e_q)*W +: W] <= move_q;
    end
  end

  assign jogadaIgualMemoria     = (mem_rd == move_q);
  assign enderecoIgualSequencia = (e_q == s_q);
  assign tem_jogada             = tem_q;
  assign fimS                   = (s_q == E_LAST);
  assign fimLedsOn              = (on_q == ON_MAX);
  assign fimLedsOff             = (off_q == OFF_MAX);
  assign timeout                = tout_q;
  assign jogada_valida          = $onehot(move_q);
  assign leds                   = leds_q;
  assign db_endereco            = e_q;
  assign db_sequencia           = s_q;
  assign db_memoria             = mem_rd;
  assign db_jogada              = move_q;

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Bench for fluxo_dados_param: default instance plus a scaled one (W=3, DEPTH=8, T_ON=T_OFF=4, T_TO=8).
module tb_fluxo_dados_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, zeraE, contaE, zeraS, contaS, zeraR, registraR, escreveM;
  logic esp, lon, loff;
  logic [3:0] ch;

  logic a_jim, a_eis, a_tem, a_fimS, a_fon, a_foff, a_to, a_jv;
  logic [3:0] a_leds, a_dbe, a_dbs, a_dbm, a_dbj;
  logic b_jim, b_eis, b_tem, b_fimS, b_fon, b_foff, b_to, b_jv;
  logic [2:0] b_leds, b_dbe, b_dbs, b_dbm, b_dbj;

  fluxo_dados_param dut_a (
    .clock(clk), .reset(rst), .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .estado_espera(esp), .estado_ledsOn(lon), .estado_ledsOff(loff), .chaves(ch),
    .jogadaIgualMemoria(a_jim), .enderecoIgualSequencia(a_eis), .tem_jogada(a_tem),
    .fimS(a_fimS), .fimLedsOn(a_fon), .fimLedsOff(a_foff), .timeout(a_to),
    .jogada_valida(a_jv), .leds(a_leds), .db_endereco(a_dbe), .db_sequencia(a_dbs),
    .db_memoria(a_dbm), .db_jogada(a_dbj)
  );

  fluxo_dados_param #(.W(3), .DEPTH(8), .T_ON(4), .T_OFF(4), .T_TO(8)) dut_b (
    .clock(clk), .reset(rst), .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM),
    .estado_espera(esp), .estado_ledsOn(lon), .estado_ledsOff(loff), .chaves(ch[2:0]),
    .jogadaIgualMemoria(b_jim), .enderecoIgualSequencia(b_eis), .tem_jogada(b_tem),
    .fimS(b_fimS), .fimLedsOn(b_fon), .fimLedsOff(b_foff), .timeout(b_to),
    .jogada_valida(b_jv), .leds(b_leds), .db_endereco(b_dbe), .db_sequencia(b_dbs),
    .db_memoria(b_dbm), .db_jogada(b_dbj)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = default instance, 1 = scaled instance.
  int PW[2]   = '{4, 3};
  int PD[2]   = '{16, 8};
  int PON[2]  = '{50, 4};
  int POFF[2] = '{50, 4};
  int PTO[2]  = '{5000, 8};

  int me[2], ms[2], mon[2], moff[2], mto[2], mmv[2], mled[2], mflag[2], mhist[2], mtem[2];
  int mmem[2][16];
  bit m_valid = 1'b0;
  bit m_init  = 1'b0;

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim - 1) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    int chv, rd;
    bit keys;
    if (!m_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++)
          mmem[k][i] = 1 << (i % PW[k]);
      m_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      chv  = int'(ch) & ((1 << PW[k]) - 1);
      keys = (chv != 0);
      if (rst) begin
        me[k] = 0; ms[k] = 0; mon[k] = 0; moff[k] = 0; mto[k] = 0;
        mmv[k] = 0; mled[k] = 0; mflag[k] = 0; mhist[k] = 0; mtem[k] = 0;
      end else begin
        rd = mmem[k][me[k]];
        if (escreveM) mmem[k][me[k]] = mmv[k];
        mflag[k] = zeraR ? 0 : ((mflag[k] != 0 || mto[k] == PTO[k] - 1) ? 1 : 0);
        mto[k]   = (zeraE || keys) ? 0 : (esp ? sat_inc(mto[k], PTO[k]) : mto[k]);
        mled[k]  = (zeraR || loff || esp) ? 0 : (lon ? rd : mled[k]);
        mon[k]   = loff ? 0 : (lon ? sat_inc(mon[k], PON[k]) : mon[k]);
        moff[k]  = lon ? 0 : (loff ? sat_inc(moff[k], POFF[k]) : moff[k]);
        me[k]    = zeraE ? 0 : (contaE ? (me[k] + 1) % PD[k] : me[k]);
        ms[k]    = zeraS ? 0 : (contaS ? (ms[k] + 1) % PD[k] : ms[k]);
        mmv[k]   = zeraR ? 0 : (registraR ? chv : mmv[k]);
        mtem[k]  = (keys && mhist[k] == 0) ? 1 : 0;
        mhist[k] = keys ? 1 : 0;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("A_jim",  int'(a_jim),  int'(mmem[0][me[0]] == mmv[0]));
      chk("A_eis",  int'(a_eis),  int'(me[0] == ms[0]));
      chk("A_tem",  int'(a_tem),  mtem[0]);
      chk("A_fimS", int'(a_fimS), int'(ms[0] == PD[0] - 1));
      chk("A_fon",  int'(a_fon),  int'(mon[0] == PON[0] - 1));
      chk("A_foff", int'(a_foff), int'(moff[0] == POFF[0] - 1));
      chk("A_to",   int'(a_to),   mflag[0]);
      chk("A_jv",   int'(a_jv),   int'($countones(mmv[0]) == 1));
      chk("A_leds", int'(a_leds), mled[0]);
      chk("A_dbe",  int'(a_dbe),  me[0]);
      chk("A_dbs",  int'(a_dbs),  ms[0]);
      chk("A_dbm",  int'(a_dbm),  mmem[0][me[0]]);
      chk("A_dbj",  int'(a_dbj),  mmv[0]);
      chk("B_jim",  int'(b_jim),  int'(mmem[1][me[1]] == mmv[1]));
      chk("B_eis",  int'(b_eis),  int'(me[1] == ms[1]));
      chk("B_tem",  int'(b_tem),  mtem[1]);
      chk("B_fimS", int'(b_fimS), int'(ms[1] == PD[1] - 1));
      chk("B_fon",  int'(b_fon),  int'(mon[1] == PON[1] - 1));
      chk("B_foff", int'(b_foff), int'(moff[1] == POFF[1] - 1));
      chk("B_to",   int'(b_to),   mflag[1]);
      chk("B_jv",   int'(b_jv),   int'($countones(mmv[1]) == 1));
      chk("B_leds", int'(b_leds), mled[1]);
      chk("B_dbe",  int'(b_dbe),  me[1]);
      chk("B_dbs",  int'(b_dbs),  ms[1]);
      chk("B_dbm",  int'(b_dbm),  mmem[1][me[1]]);
      chk("B_dbj",  int'(b_dbj),  mmv[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pa, pb;

  initial begin
    rst = 1'b1; zeraE = 0; contaE = 0; zeraS = 0; contaS = 0; zeraR = 0;
    registraR = 0; escreveM = 0; esp = 0; lon = 0; loff = 0; ch = 4'b0000;
    step(); step();
    rst = 1'b0;
    chk("rst_leds", int'(a_leds), 0);
    chk("rst_dbe",  int'(a_dbe), 0);
    chk("rst_to",   int'(a_to), 0);
    chk("rst_fon",  int'(a_fon), 0);
    chk("rst_fimS", int'(b_fimS), 0);

    // Address counter wrap and clear priority
    contaE = 1; repeat (17) step();
    chk("wrapA_dbe", int'(a_dbe), 1);
    chk("wrapB_dbe", int'(b_dbe), 1);
    zeraE = 1; step(); zeraE = 0; contaE = 0;
    chk("clrA_dbe", int'(a_dbe), 0);
    chk("clrB_dbe", int'(b_dbe), 0);

    contaS = 1; repeat (15) step(); contaS = 0;
    chk("fimS_A", int'(a_fimS), 1);
    chk("fimS_B", int'(b_fimS), 1);
    chk("eis_A_ne", int'(a_eis), 0);
    zeraS = 1; step(); zeraS = 0;
    chk("fimS_A_clr", int'(a_fimS), 0);
    chk("eis_A_eq", int'(a_eis), 1);

    // LEDs-on window at E=3, then LEDs-off window
    contaE = 1; repeat (3) step(); contaE = 0;
    lon = 1; step();
    chk("ledsA_E3", int'(a_leds), 8);
    chk("ledsB_E3", int'(b_leds), 1);
    for (int i = 2; i <= 49; i++) begin
      step();
      if (i == 2)  chk("fonB_early", int'(b_fon), 0);
      if (i == 3)  chk("fonB_end", int'(b_fon), 1);
      if (i == 48) chk("fonA_early", int'(a_fon), 0);
      if (i == 49) chk("fonA_end", int'(a_fon), 1);
    end
    lon = 0; loff = 1; step();
    chk("ledsA_off", int'(a_leds), 0);
    chk("ledsB_off", int'(b_leds), 0);
    chk("fonA_clr", int'(a_fon), 0);
    for (int i = 2; i <= 49; i++) begin
      step();
      if (i == 3)  chk("foffB_end", int'(b_foff), 1);
      if (i == 48) chk("foffA_early", int'(a_foff), 0);
      if (i == 49) chk("foffA_end", int'(a_foff), 1);
    end
    loff = 0;

    // Move detection and register
    ch = 4'b0100; pa = 0; pb = 0;
    repeat (5) begin
      step();
      if (a_tem) pa++;
      if (b_tem) pb++;
    end
    registraR = 1; step(); registraR = 0; ch = 4'b0000;
    chk("temA_pulses", pa, 1);
    chk("temB_pulses", pb, 1);
    chk("dbjA", int'(a_dbj), 4);
    chk("dbjB", int'(b_dbj), 4);
    chk("jvA", int'(a_jv), 1);
    chk("jvB", int'(b_jv), 1);
    zeraE = 1; step(); zeraE = 0;
    contaE = 1; repeat (2) step(); contaE = 0;
    chk("jimA_E2", int'(a_jim), 1);
    chk("jimB_E2", int'(b_jim), 1);
    contaE = 1; step(); contaE = 0;
    chk("jimA_E3", int'(a_jim), 0);
    chk("jimB_E3", int'(b_jim), 0);

    // Memory write at E=5 survives reset
    ch = 4'b0010; registraR = 1; step(); registraR = 0; ch = 4'b0000;
    contaE = 1; repeat (2) step(); contaE = 0;
    escreveM = 1; step(); escreveM = 0;
    chk("memA_wr", int'(a_dbm), 2);
    chk("memB_wr", int'(b_dbm), 2);
    rst = 1; step(); rst = 0;
    chk("dbeA_rst", int'(a_dbe), 0);
    contaE = 1; repeat (5) step(); contaE = 0;
    chk("memA_keep", int'(a_dbm), 2);
    chk("memB_keep", int'(b_dbm), 2);
    ch = 4'b0001; registraR = 1; step(); registraR = 0; ch = 4'b0000;
    escreveM = 1; step(); escreveM = 0;
    chk("memA_wr2", int'(a_dbm), 1);
    chk("memB_wr2", int'(b_dbm), 1);

    // Timeout while waiting, sticky until zeraR
    zeraR = 1; step(); zeraR = 0;
    esp = 1;
    for (int i = 1; i <= 5000; i++) begin
      step();
      if (i == 7)    chk("toB_early", int'(b_to), 0);
      if (i == 8)    chk("toB_set", int'(b_to), 1);
      if (i == 4999) chk("toA_early", int'(a_to), 0);
      if (i == 5000) chk("toA_set", int'(a_to), 1);
    end
    ch = 4'b0001; step(); ch = 4'b0000;
    chk("toA_sticky", int'(a_to), 1);
    chk("toB_sticky", int'(b_to), 1);
    chk("ledsA_esp", int'(a_leds), 0);
    zeraR = 1; step(); zeraR = 0; esp = 0;
    chk("toA_clr", int'(a_to), 0);
    chk("toB_clr", int'(b_to), 0);

    // Reset aborts an LEDs-on window
    lon = 1; repeat (10) step();
    rst = 1; step(); rst = 0;
    for (int i = 1; i <= 49; i++) begin
      step();
      if (i == 2)  chk("rstB_fon_early", int'(b_fon), 0);
      if (i == 3)  chk("rstB_fon_end", int'(b_fon), 1);
      if (i == 48) chk("rstA_fon_early", int'(a_fon), 0);
      if (i == 49) chk("rstA_fon_end", int'(a_fon), 1);
    end
    lon = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
